// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and the default width.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef logic [2:0] mdOp_t;

    localparam mdOp_t OP_MULT  = 3'd0;
    localparam mdOp_t OP_MULTU = 3'd1;
    localparam mdOp_t OP_DIV   = 3'd2;
    localparam mdOp_t OP_DIVU  = 3'd3;
    localparam mdOp_t OP_MADD  = 3'd4;
    localparam mdOp_t OP_MADDU = 3'd5;
    localparam mdOp_t OP_MSUB  = 3'd6;
    localparam mdOp_t OP_MSUBU = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic isDivOp(input mdOp_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Even encodings are the signed variants of each op pair.
    function automatic logic isSignedOp(input mdOp_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational datapath: one shift-add or restoring shift-subtract step per call,
// plus the sign/accumulate fixup that turns raw magnitudes into Hi/Lo results.
module muldiv_core
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  mdOp_t                op,
    input  logic [WIDTH-1:0]     stepOperand,
    input  logic [WIDTH:0]       remIn,
    input  logic [2*WIDTH-1:0]   workIn,
    input  logic [WIDTH-1:0]     aRaw,
    input  logic [WIDTH-1:0]     bRaw,
    input  logic [WIDTH-1:0]     hiIn,
    input  logic [WIDTH-1:0]     loIn,
    output logic [WIDTH:0]       remNext,
    output logic [2*WIDTH-1:0]   workNext,
    output logic [WIDTH-1:0]     hiOut,
    output logic [WIDTH-1:0]     loOut,
    output logic                 divZero
);

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;

    // Multiply: workIn holds {partial product, remaining multiplier bits}.
    assign mulSum  = {1'b0, workIn[2*WIDTH-1:WIDTH]} + (workIn[0] ? {1'b0, stepOperand} : '0);
    // Divide: workIn low half shifts the dividend out and the quotient in.
    assign shifted = {remIn[WIDTH-1:0], workIn[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, stepOperand};

    always_comb begin
        remNext  = remIn;
        workNext = {mulSum, workIn[WIDTH-1:1]};
        if (isDivOp(op)) begin
            if (diff[WIDTH+1]) begin
                remNext  = shifted;
                workNext = {workIn[2*WIDTH-1:WIDTH], workIn[WIDTH-2:0], 1'b0};
            end else begin
                remNext  = diff[WIDTH:0];
                workNext = {workIn[2*WIDTH-1:WIDTH], workIn[WIDTH-2:0], 1'b1};
            end
        end
    end

    logic                 signsDiffer;
    logic [2*WIDTH-1:0]   signedProd;
    logic [2*WIDTH-1:0]   accum;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;

    always_comb begin
        signsDiffer = isSignedOp(op) & (aRaw[WIDTH-1] ^ bRaw[WIDTH-1]);
        signedProd  = signsDiffer ? -workIn : workIn;
        accum       = {hiIn, loIn};
        quot        = signsDiffer ? -workIn[WIDTH-1:0] : workIn[WIDTH-1:0];
        rem         = (isSignedOp(op) & aRaw[WIDTH-1]) ? -remIn[WIDTH-1:0] : remIn[WIDTH-1:0];
        divZero     = isDivOp(op) && (bRaw == '0);
        result      = signedProd;
        if (op[2]) begin
            result = op[1] ? (accum - signedProd) : (accum + signedProd);
        end
        {hiOut, loOut} = result;
        if (isDivOp(op)) begin
            // Divide by zero reports the dividend untouched in Hi and all-ones in Lo.
            hiOut = divZero ? aRaw : rem;
            loOut = divZero ? '1   : quot;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding the Hi/Lo register; fixed 34-cycle latency.
//  state   | meaning
//  S_IDLE  | waiting for Start, operands captured on acceptance
//  S_RUN   | one shift-add / shift-subtract iteration per cycle, WIDTH cycles
//  S_FIXUP | apply sign correction, accumulate and divide-by-zero result
//  S_DONE  | Done/WriteHi/WriteLo high for this single cycle
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [2:0]         Op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   HiIn,
    input  logic [WIDTH-1:0]   LoIn,
    output logic               Busy,
    output logic               Done,
    output logic               WriteHi,
    output logic               WriteLo,
    output logic [WIDTH-1:0]   WriteData1,
    output logic [WIDTH-1:0]   WriteData2,
    output logic               DivZero
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]           state;
    logic [CNT_W-1:0]     count;
    mdOp_t                opReg;
    logic [WIDTH-1:0]     aReg;
    logic [WIDTH-1:0]     bReg;
    logic [WIDTH-1:0]     hiReg;
    logic [WIDTH-1:0]     loReg;
    logic [WIDTH-1:0]     stepOperand;
    logic [WIDTH:0]       remReg;
    logic [2*WIDTH-1:0]   workReg;

    logic [WIDTH:0]       remNext;
    logic [2*WIDTH-1:0]   workNext;
    logic [WIDTH-1:0]     hiOut;
    logic [WIDTH-1:0]     loOut;
    logic                 divZeroNext;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;

    assign magA = (isSignedOp(Op) && A[WIDTH-1]) ? -A : A;
    assign magB = (isSignedOp(Op) && B[WIDTH-1]) ? -B : B;

    muldiv_core #(.WIDTH(WIDTH)) core (
        .op          (opReg),
        .stepOperand (stepOperand),
        .remIn       (remReg),
        .workIn      (workReg),
        .aRaw        (aReg),
        .bRaw        (bReg),
        .hiIn        (hiReg),
        .loIn        (loReg),
        .remNext     (remNext),
        .workNext    (workNext),
        .hiOut       (hiOut),
        .loOut       (loOut),
        .divZero     (divZeroNext)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= S_IDLE;
            count       <= '0;
            opReg       <= '0;
            aReg        <= '0;
            bReg        <= '0;
            hiReg       <= '0;
            loReg       <= '0;
            stepOperand <= '0;
            remReg      <= '0;
            workReg     <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            WriteHi     <= 1'b0;
            WriteLo     <= 1'b0;
            DivZero     <= 1'b0;
            WriteData1  <= '0;
            WriteData2  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        opReg  <= Op;
                        aReg   <= A;
                        bReg   <= B;
                        hiReg  <= HiIn;
                        loReg  <= LoIn;
                        count  <= '0;
                        remReg <= '0;
                        // Divide iterates on the dividend; multiply walks the multiplier bits.
                        if (isDivOp(Op)) begin
                            workReg     <= {{WIDTH{1'b0}}, magA};
                            stepOperand <= magB;
                        end else begin
                            workReg     <= {{WIDTH{1'b0}}, magB};
                            stepOperand <= magA;
                        end
                        Busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    workReg <= workNext;
                    remReg  <= remNext;
                    count   <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    WriteData1 <= hiOut;
                    WriteData2 <= loOut;
                    DivZero    <= divZeroNext;
                    Done       <= 1'b1;
                    WriteHi    <= 1'b1;
                    WriteLo    <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    Done    <= 1'b0;
                    WriteHi <= 1'b0;
                    WriteLo <= 1'b0;
                    DivZero <= 1'b0;
                    Busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
